// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared state type and frame-length helper for piso_serializer (PISO_PARITY_EN appends a parity bit)
package piso_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } piso_state_t;

`ifdef PISO_PARITY_EN
   localparam bit PARITY_EN = 1'b1;
`else
   localparam bit PARITY_EN = 1'b0;
`endif

   // Number of bit slots in one frame: the data bits plus an optional parity slot.
   function automatic int frame_len(input int width, input bit parity);
      return parity ? width + 1 : width;
   endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// rtl/piso_bit_counter.sv - frame bit counter with clear, increment and terminal-count flag
module piso_bit_counter #(
   parameter int FRAME_LEN = 8,
   parameter int CNT_W     = $clog2(FRAME_LEN)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_clear,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_count,
   output logic             o_last
);

   logic [CNT_W-1:0] r_count;

   // Clear wins over increment; the count stops at the terminal value so it never passes FRAME_LEN-1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_inc && !o_last) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign o_count = r_count;
   assign o_last  = (r_count == CNT_W'(FRAME_LEN - 1));

endmodule

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out transmitter with back-to-back frames (PISO_PARITY_EN adds even parity)
module piso_serializer
   import piso_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             frame_start,
   output logic             busy
);

   localparam int FRAME_LEN = frame_len(WIDTH, PARITY_EN);
   localparam int CNT_W     = $clog2(FRAME_LEN);

   piso_state_t      r_state;
   piso_state_t      w_next_state;
   logic [WIDTH-1:0] r_shift;
   logic             r_ser_out;
   logic             r_ser_valid;
   logic             r_frame_start;

   logic [CNT_W-1:0] w_count;
   logic             w_last;
   logic             w_in_ready;
   logic             w_accept;
   logic             w_clear;
   logic             w_inc;
   logic             w_first_bit;
   logic             w_data_bit;
   logic             w_next_bit;
   logic [WIDTH-1:0] w_load;
   logic [WIDTH-1:0] w_shifted;

   // w_last is only ever true in SHIFT, so IDLE never sees a terminal count.
   assign w_in_ready = (r_state == IDLE) || ((r_state == SHIFT) && w_last);
   assign w_accept   = in_valid && w_in_ready;

   // Counter restarts on every reload and returns to 0 when a frame ends without a follow-on word.
   assign w_clear = w_accept || ((r_state == SHIFT) && w_last);
   assign w_inc   = (r_state == SHIFT);

   piso_bit_counter #(
      .FRAME_LEN (FRAME_LEN),
      .CNT_W     (CNT_W)
   ) u_bit_counter (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clear (w_clear),
      .i_inc   (w_inc),
      .o_count (w_count),
      .o_last  (w_last)
   );

   // The first bit goes straight to ser_out on accept, so the shift register holds only the bits still to come.
   assign w_first_bit = LSB_FIRST ? in_data[0] : in_data[WIDTH-1];
   assign w_load      = LSB_FIRST ? (in_data >> 1) : (in_data << 1);
   assign w_data_bit  = LSB_FIRST ? r_shift[0] : r_shift[WIDTH-1];
   assign w_shifted   = LSB_FIRST ? (r_shift >> 1) : (r_shift << 1);

`ifdef PISO_PARITY_EN
   logic r_parity;

   // Even parity of the accepted word, held for the slot after the last data bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_parity <= 1'b0;
      end else if (w_accept) begin
         r_parity <= ^in_data;
      end
   end

   assign w_next_bit = (w_count == CNT_W'(WIDTH - 1)) ? r_parity : w_data_bit;
`else
   logic w_unused_count;

   assign w_next_bit     = w_data_bit;
   assign w_unused_count = ^w_count;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next state: enter SHIFT on accept, leave only when the last bit has no follow-on word.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_next_state = SHIFT;
            end
         end
         SHIFT: begin
            if (w_last && !w_accept) begin
               w_next_state = IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   // Shift datapath and registered serial outputs; outside a frame everything rests at 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shift       <= '0;
         r_ser_out     <= 1'b0;
         r_ser_valid   <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         r_ser_valid   <= (w_next_state == SHIFT);
         r_frame_start <= w_accept;
         if (w_accept) begin
            r_shift   <= w_load;
            r_ser_out <= w_first_bit;
         end else if ((r_state == SHIFT) && !w_last) begin
            r_shift   <= w_shifted;
            r_ser_out <= w_next_bit;
         end else begin
            r_shift   <= '0;
            r_ser_out <= 1'b0;
         end
      end
   end

   assign in_ready    = w_in_ready;
   assign ser_out     = r_ser_out;
   assign ser_valid   = r_ser_valid;
   assign frame_start = r_frame_start;
   assign busy        = (r_state == SHIFT);

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - self-checking bench for piso_serializer, both bit orders against a frame-level model
module tb_piso_serializer;
   import piso_pkg::*;

   localparam int W = 8;
`ifdef PISO_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif
   localparam int FL = frame_len(W, PAR);

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic [W-1:0] in_data;

   logic ready_l, ser_l, val_l, fs_l, busy_l;
   logic ready_m, ser_m, val_m, fs_m, busy_m;

   int           n_assert;
   int           n_fail;
   int           cyc;

   bit           m_active;
   int           m_idx;
   logic [W-1:0] m_word;

   piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (ready_l),
      .in_data     (in_data),
      .ser_out     (ser_l),
      .ser_valid   (val_l),
      .frame_start (fs_l),
      .busy        (busy_l)
   );

   piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (ready_m),
      .in_data     (in_data),
      .ser_out     (ser_m),
      .ser_valid   (val_m),
      .frame_start (fs_m),
      .busy        (busy_m)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Bit number idx of a frame: data bits in wire order, then the parity slot.
   function automatic logic exp_bit(input logic [W-1:0] w, input int idx, input bit lsb);
      if (idx >= W) return ^w;
      return lsb ? w[idx] : w[W-1-idx];
   endfunction

   task automatic check_outputs();
      logic e_l, e_m, e_fs;
      e_l  = m_active ? exp_bit(m_word, m_idx, 1'b1) : 1'b0;
      e_m  = m_active ? exp_bit(m_word, m_idx, 1'b0) : 1'b0;
      e_fs = m_active && (m_idx == 0);
      check($sformatf("lsb ser_out cyc%0d", cyc), ser_l, e_l);
      check($sformatf("lsb ser_valid cyc%0d", cyc), val_l, m_active);
      check($sformatf("lsb frame_start cyc%0d", cyc), fs_l, e_fs);
      check($sformatf("lsb busy cyc%0d", cyc), busy_l, m_active);
      check($sformatf("msb ser_out cyc%0d", cyc), ser_m, e_m);
      check($sformatf("msb ser_valid cyc%0d", cyc), val_m, m_active);
      check($sformatf("msb frame_start cyc%0d", cyc), fs_m, e_fs);
      check($sformatf("msb busy cyc%0d", cyc), busy_m, m_active);
   endtask

   // One clock: drive inputs, check in_ready before the edge, advance the model, check outputs after it.
   task automatic cycle(input logic v, input logic [W-1:0] d);
      bit exp_rdy;
      in_valid = v;
      in_data  = d;
      #1;
      exp_rdy = !m_active || (m_idx == FL - 1);
      check($sformatf("lsb in_ready cyc%0d", cyc), ready_l, exp_rdy);
      check($sformatf("msb in_ready cyc%0d", cyc), ready_m, exp_rdy);
      @(posedge clk);
      #1;
      cyc++;
      if (v && exp_rdy) begin
         m_word   = d;
         m_idx    = 0;
         m_active = 1'b1;
      end else if (m_active) begin
         if (m_idx == FL - 1) m_active = 1'b0;
         else m_idx++;
      end
      check_outputs();
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      cyc      = 0;
      m_active = 1'b0;
      m_idx    = 0;
      m_word   = '0;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;

      // Held in reset: everything quiet, in_ready already high.
      repeat (2) @(posedge clk);
      #1;
      check_outputs();
      check("lsb in_ready in reset", ready_l, 1'b1);
      check("msb in_ready in reset", ready_m, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;

      // Single frames: A5, then 80 (MSB-first sends the 1 first).
      cycle(1'b1, 8'hA5);
      repeat (FL + 1) cycle(1'b0, 8'($urandom));
      cycle(1'b1, 8'h80);
      repeat (FL + 1) cycle(1'b0, 8'($urandom));

      // Back-to-back A5 then 3C with in_valid held high.
      cycle(1'b1, 8'hA5);
      repeat (FL) cycle(1'b1, 8'h3C);
      repeat (FL + 1) cycle(1'b0, 8'($urandom));

      // Odd-parity word.
      cycle(1'b1, 8'h07);
      repeat (FL + 1) cycle(1'b0, 8'($urandom));

      // Reset during cycle 4 of a frame, then a clean 01 frame on the first edge after release.
      cycle(1'b1, 8'($urandom));
      repeat (3) cycle(1'b0, 8'($urandom));
      #2;
      rst_n = 1'b0;
      #1;
      m_active = 1'b0;
      m_idx    = 0;
      check_outputs();
      check("lsb in_ready async reset", ready_l, 1'b1);
      check("msb in_ready async reset", ready_m, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      cycle(1'b1, 8'h01);
      repeat (FL + 1) cycle(1'b0, 8'($urandom));

      // Random traffic: in_valid and in_data churn mid-frame.
      for (int i = 0; i < 80; i++) begin
         cycle(($urandom_range(0, 3) != 0), 8'($urandom));
      end
      repeat (FL + 1) cycle(1'b0, 8'($urandom));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
